// File: rtl/bcd_cnt_pkg.sv
// Shared BCD constants and the load-value clamp used by the up/down counter.
package bcd_cnt_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  // Non-decimal nibbles (A..F) saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: holds, loads a clamped nibble, or steps up/down with wrap.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       LOAD,
  input  logic       UP,
  input  logic       step,
  input  logic [3:0] d_in,
  input  logic [3:0] rst_val,
  output logic [3:0] q,
  output logic       tc,
  output logic       clamped
);

  logic [3:0] q_cnt;
  logic [3:0] q_nxt;

  // Single-digit increment/decrement with 9<->0 wrap.
  always_comb begin
    q_cnt = q;
    if (UP) begin
      q_cnt = (q == BCD_MAX) ? BCD_MIN : 4'(q + 4'd1);
    end else begin
      q_cnt = (q == BCD_MIN) ? BCD_MAX : 4'(q - 4'd1);
    end
  end

  always_comb begin
    q_nxt = q;
    if (EN) begin
      if (!LOAD) begin
        q_nxt = bcd_clamp(d_in);
      end else if (step) begin
        q_nxt = q_cnt;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q <= rst_val;
    end else begin
      q <= q_nxt;
    end
  end

  assign tc      = UP ? (q == BCD_MAX) : (q == BCD_MIN);
  assign clamped = (d_in > BCD_MAX);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter, modulo 10^DIGITS, with load clamp flag.
// Define BCD_CNT_SAT_EN to saturate at the terminal value instead of wrapping.
module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter  int unsigned         DIGITS  = 4,
  localparam int unsigned         W       = NIB_W * DIGITS,
  parameter  logic [W-1:0]        RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              EN,
  input  logic              LOAD,
  input  logic              UP,
  input  logic [W-1:0]      DATA,
  output logic [W-1:0]      DOUT,
  output logic [DIGITS-1:0] DIG_TC,
  output logic              COUT,
  output logic              LOAD_ERR
);

  logic              sat_hold;
  logic [DIGITS-1:0] clamped;

  assign COUT = &DIG_TC;

`ifdef BCD_CNT_SAT_EN
  // At the terminal value in the current direction, freeze the whole chain.
  assign sat_hold = COUT;
`else
  assign sat_hold = 1'b0;
`endif

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_dig
    logic lower_tc;
    logic step;

    if (i == 0) begin : g_lsd
      assign lower_tc = 1'b1;
    end else begin : g_upper
      assign lower_tc = &DIG_TC[i-1:0];
    end

    assign step = EN & LOAD & lower_tc & ~sat_hold;

    bcd_digit u_digit (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .EN      (EN),
      .LOAD    (LOAD),
      .UP      (UP),
      .step    (step),
      .d_in    (DATA[NIB_W*i +: NIB_W]),
      .rst_val (RST_VAL[NIB_W*i +: NIB_W]),
      .q       (DOUT[NIB_W*i +: NIB_W]),
      .tc      (DIG_TC[i]),
      .clamped (clamped[i])
    );
  end

  // Flags a load that clamped any digit; cleared by the next enabled count.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      LOAD_ERR <= 1'b0;
    end else if (EN) begin
      LOAD_ERR <= ~LOAD & (|clamped);
    end
  end

endmodule
